// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//
// Architectural GPR bank for the URCPU datapath. It has one synchronous write
// port, two combinational read ports with write-through bypass, and a debug
// dump reader that streams every register out over a valid/ready handshake.
// Register 0 is hardwired to zero on every read path, including the dump.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   WE         write enable
//   waddr      write address
//   wdata      write data
//   raddr_a    read port A address    -> rdata_a (combinational)
//   raddr_b    read port B address    -> rdata_b (combinational)
//   dump_req   start a full dump (sampled only while idle)
//   dump_valid dump beat presented
//   dump_ready consumer accepts the current beat
//   dump_idx   register index of the current beat
//   dump_data  captured contents of register dump_idx
//   dump_busy  high while a dump is in progress
// -----------------------------------------------------------------------------
module regfile_dump #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic [ADDR_W-1:0] idx_inc;
    logic [WIDTH-1:0]  hold;
    logic [WIDTH-1:0]  hold_next;

    // Shared read rule for both read ports and the dump capture: r0 is zero,
    // a write presented this cycle to the same address is forwarded, else the
    // stored word is returned.
    function automatic logic [WIDTH-1:0] read_word(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [WIDTH-1:0]  wd
    );
        if (addr == '0)
            return '0;
        if (we && (wa == addr))
            return wd;
        return stored;
    endfunction

    assign rdata_a = read_word(raddr_a, regs[raddr_a], WE, waddr, wdata);
    assign rdata_b = read_word(raddr_b, regs[raddr_b], WE, waddr, wdata);

    assign idx_inc = idx + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            // Writes to r0 are dropped so the storage word stays zero too.
            if (WE && (waddr != '0))
                regs[waddr] <= wdata;
            state <= state_next;
            idx   <= idx_next;
            hold  <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        hold_next  = hold;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        unique case (state)
            IDLE: begin
                if (dump_req) begin
                    state_next = SEND;
                    idx_next   = '0;
                    hold_next  = '0;
                end
            end
            SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (idx == ADDR_W'(DEPTH - 1)) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        // Capture the next word now, honouring a same-cycle
                        // write, so the beat is frozen until it is accepted.
                        idx_next  = idx_inc;
                        hold_next = read_word(idx_inc, regs[idx_inc], WE, waddr, wdata);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dump_idx  = idx;
    assign dump_data = hold;

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              WE;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  rdata_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_b;
    logic              dump_req;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_idx;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_busy;

    regfile_dump #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .WE(WE), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents plus the dump's progress.
    int mreg [DEPTH];
    bit m_active;   // a dump is in progress
    bit m_known;    // idle dump outputs are defined (after reset, before any dump)
    int m_idx;      // index of the beat currently offered
    int m_cap;      // value captured for that beat

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_read(input int a);
        if (a == 0) return 0;
        if (WE && (int'(waddr) == a)) return int'(wdata);
        return mreg[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mreg[i] = 0;
        m_active = 0;
        m_known  = 1;
        m_idx    = 0;
        m_cap    = 0;
    endtask

    // Check all outputs against the model for the currently applied inputs,
    // then advance one clock and update the model.
    task automatic tick();
        #1;
        check("rdata_a", rdata_a, exp_read(int'(raddr_a)));
        check("rdata_b", rdata_b, exp_read(int'(raddr_b)));
        check("dump_valid", dump_valid, m_active);
        check("dump_busy", dump_busy, m_active);
        if (m_active || m_known) begin
            check("dump_idx", dump_idx, m_idx);
            check("dump_data", dump_data, m_cap);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (WE && waddr != 0) mreg[waddr] = int'(wdata);
            if (!m_active) begin
                if (dump_req) begin
                    m_active = 1;
                    m_known  = 0;
                    m_idx    = 0;
                    m_cap    = 0;
                end
            end else if (dump_ready) begin
                if (m_idx == DEPTH - 1) begin
                    m_active = 0;
                end else begin
                    m_idx = m_idx + 1;
                    m_cap = mreg[m_idx];
                end
            end
        end
        #1;
    endtask

    int beats;
    bit hit;

    initial begin
        rst = 1; WE = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
        dump_req = 0; dump_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;

        // Everything reads zero after reset.
        for (int a = 0; a < DEPTH; a++) begin
            raddr_a = ADDR_W'(a);
            raddr_b = ADDR_W'(DEPTH - 1 - a);
            tick();
        end
        check("reset_valid", dump_valid, 0);
        check("reset_busy", dump_busy, 0);
        check("reset_idx", dump_idx, 0);
        check("reset_data", dump_data, 0);

        // Basic writes, including a discarded write to r0.
        WE = 1; waddr = 3; wdata = 8'hA5; tick();
        waddr = 7; wdata = 8'h3C; tick();
        waddr = 0; wdata = 8'hFF; tick();
        WE = 0; raddr_a = 3; raddr_b = 7; tick();
        check("read_r3", rdata_a, 8'hA5);
        check("read_r7", rdata_b, 8'h3C);
        raddr_a = 0; tick();
        check("read_r0", rdata_a, 8'h00);

        // Same-cycle write-through bypass.
        WE = 1; waddr = 5; wdata = 8'h42; raddr_a = 5; #1;
        check("bypass_before_edge", rdata_a, 8'h42);
        tick();
        WE = 0; #1;
        check("r5_after_edge", rdata_a, 8'h42);

        // Full dump with ready held high.
        WE = 1;
        for (int i = 1; i < DEPTH; i++) begin
            waddr = ADDR_W'(i); wdata = WIDTH'(i * 8'h11); tick();
        end
        WE = 0;
        dump_req = 1; tick();
        dump_req = 0; dump_ready = 1;
        beats = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (dump_valid) begin
                check("beat_idx", dump_idx, beats);
                check("beat_data", dump_data, WIDTH'(beats * 8'h11));
                beats++;
            end
            tick();
        end
        check("beat_count", beats, DEPTH);
        check("idle_after_dump", dump_busy, 0);

        // Stalled dump with a write to the held register while stalled.
        dump_req = 1; dump_ready = 0; tick();
        dump_req = 0;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            dump_ready = (i % 3 == 0);
            WE = !dump_ready && (m_idx != 0);
            waddr = ADDR_W'(m_idx);
            wdata = 8'h99;
            tick();
            if (!m_active) hit = 1;
        end
        WE = 0;
        check("stall_dump_done", dump_busy, 0);

        // Reset during beat 4.
        dump_req = 1; dump_ready = 0; tick();
        dump_req = 0; dump_ready = 1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (dump_valid && dump_idx == 4) hit = 1;
            else tick();
        end
        check("reached_beat4", dump_idx, 4);
        rst = 1; dump_ready = 0; tick();
        rst = 0;
        check("rst_valid", dump_valid, 0);
        check("rst_busy", dump_busy, 0);
        check("rst_idx", dump_idx, 0);
        for (int a = 0; a < DEPTH; a++) begin
            raddr_a = ADDR_W'(a); raddr_b = ADDR_W'(a); tick();
        end
        dump_req = 1; tick();
        dump_req = 0;
        check("restart_valid", dump_valid, 1);
        check("restart_idx", dump_idx, 0);
        dump_ready = 1;
        repeat (DEPTH + 1) tick();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(63) == 0);
            WE         = $urandom_range(1);
            waddr      = ADDR_W'($urandom);
            wdata      = WIDTH'($urandom);
            raddr_a    = ADDR_W'($urandom);
            raddr_b    = ($urandom_range(3) == 0) ? waddr : ADDR_W'($urandom);
            dump_req   = ($urandom_range(7) == 0);
            dump_ready = ($urandom_range(3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Register file for the URCPU datapath: a bank of write-enabled storage words with one synchronous write port and two combinational read ports. It also has a debug dump reader that streams every register out over a valid/ready handshake. Instruction execution uses it as the architectural GPR bank. The debug path uses it to read back machine state without stalling writes.

## Interface
Parameters:
- WIDTH, 8, data bits per register
- DEPTH, 8, number of registers; power of two, at least 2
- ADDR_W, 3, address width; must equal log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- WE  input  1  write enable for the write port
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- raddr_a  input  ADDR_W  read port A address
- rdata_a  output  WIDTH  read port A data (combinational)
- raddr_b  input  ADDR_W  read port B address
- rdata_b  output  WIDTH  read port B data (combinational)
- dump_req  input  1  start a full dump; sampled in IDLE only
- dump_valid  output  1  dump beat is presented
- dump_ready  input  1  consumer accepts the beat
- dump_idx  output  ADDR_W  register index of the current beat
- dump_data  output  WIDTH  held contents of register dump_idx
- dump_busy  output  1  high while in SEND

## Operation
Register 0 always reads as 0, on both read ports and in the dump.

Write port:
- On a clk edge with WE=1 and waddr≠0, reg[waddr] takes wdata.
- A write with waddr=0 is discarded.

Read ports:
- rdata_x = 0 if raddr_x=0.
- Otherwise, if WE=1 and waddr=raddr_x, rdata_x = wdata (write-through bypass).
- Otherwise rdata_x = reg[raddr_x].

Dump FSM (state is registered):
- IDLE
  - Outputs: dump_valid=0, dump_busy=0.
  - If dump_req=1 at an edge: go to SEND, set dump_idx=0, load the hold register with 0.
- SEND
  - Outputs: dump_valid=1, dump_busy=1.
  - dump_data comes from the hold register and is stable until the beat is accepted.
  - On an edge with dump_ready=1:
    - If dump_idx=DEPTH-1: go to IDLE.
    - Otherwise: increment dump_idx and load the hold register with the value of register dump_idx+1, using the same bypass rule as the read ports.
  - If dump_ready=0, nothing changes.
  - dump_req is ignored in SEND.

A write to a register whose beat is already held does not change dump_data; the dump shows the value at capture time.

Reset sets:
- every register to 0
- state to IDLE
- dump_idx to 0
- hold register to 0

## Timing
- Write latency: 1 edge. The bypass makes the new value visible on a read port in the same cycle the write is presented.
- Reset values: dump_valid=0, dump_busy=0, dump_idx=0, dump_data=0. rdata_a and rdata_b are 0 for every address after reset.
- Reset wins over every other input at the same edge, including mid-dump; dump_valid is 0 the cycle after reset.
- dump_valid rises one cycle after the edge that samples dump_req=1.
- With dump_ready held at 1, a dump takes exactly DEPTH cycles of dump_valid=1, with dump_idx running 0 to DEPTH-1 with no gaps.
- The FSM is in IDLE the cycle after the last beat. A new dump_req can be sampled at the first edge after that.
- dump_idx wraps only by returning to IDLE; it never counts past DEPTH-1.
- Read ports and the write port work in every dump state; the dump never stalls writes.

## Test plan
- Reset, then read every address on both ports -> all 0; dump outputs 0 and dump_busy=0.
- Write 0xA5 to r3, 0x3C to r7, 0xFF to r0; read r3, r7, r0 -> 0xA5, 0x3C, 0x00.
- Present WE=1, waddr=5, wdata=0x42 with raddr_a=5 in the same cycle -> rdata_a=0x42 before the edge; reg[5]=0x42 after it.
- Preload r1..r7=0x11..0x77, pulse dump_req, hold dump_ready=1 -> 8 beats: idx 0..7, data 0x00, 0x11, …, 0x77; back in IDLE on the 9th cycle.
- Dump with dump_ready toggling 1,0,0,1… and a write of 0x99 to the held register while stalled -> dump_data is unchanged until acceptance; index order stays intact.
- Assert rst during beat 4 -> next cycle dump_valid=0, dump_busy=0, dump_idx=0, all registers 0. A fresh dump_req then restarts the dump at idx 0.
